// File: rtl/ti_adc_cal_pkg.sv
// Shared types and helpers for the TI-ADC foreground offset calibration.
// Covers the sequencer states, the trim decision and the offset-DAC mid/limit math.
package ti_adc_cal_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ACCUM,
        DECIDE,
        NEXT,
        DONE
    } cal_state_t;

    typedef enum logic [1:0] {
        DEC_UP,
        DEC_DN,
        DEC_OK
    } cal_dec_t;

    function automatic int os_mid(input int bits);
        return 1 << (bits - 1);
    endfunction

    // Trim is symmetric around mid so vosp and vosn stay inside the DAC range.
    function automatic int trim_max(input int bits);
        return os_mid(bits) - 1;
    endfunction

endpackage

// File: rtl/ti_adc_os_accum.sv
// Sample accumulator for one calibration decision.
// Also holds the comparator that sets the trim direction from the accumulated sum.
module ti_adc_os_accum
    import ti_adc_cal_pkg::*;
#(
    parameter int ADC_BITS = 9,
    parameter int AVG_LOG2 = 4,
    parameter int DEADBAND = 1
) (
    input  logic                adc_coreclk,
    input  logic                rst,
    input  logic                i_clr,
    input  logic                i_en,
    input  logic [ADC_BITS-1:0] i_data,
    output logic                o_tc,
    output cal_dec_t            o_dec
);

    localparam int SUM_W  = ADC_BITS + AVG_LOG2;
    localparam int T_I    = 1 << (ADC_BITS - 1 + AVG_LOG2);
    localparam int D_I    = DEADBAND << AVG_LOG2;
    localparam int T_HI_I = T_I + D_I;
    localparam int T_LO_I = T_I - D_I;
    localparam logic [SUM_W:0] T_HI = T_HI_I[SUM_W:0];
    localparam logic [SUM_W:0] T_LO = T_LO_I[SUM_W:0];

    logic [SUM_W-1:0]    r_sum;
    logic [AVG_LOG2-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge adc_coreclk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
            r_cnt <= '0;
        end else if (i_en) begin
            r_sum <= r_sum + {{AVG_LOG2{1'b0}}, i_data};
            r_cnt <= r_cnt + AVG_LOG2'(1);
        end
    end

    assign o_tc = i_en && (&r_cnt);

    // NOTE: o_dec gets a default first so this block can never infer a latch.
    always_comb begin
        o_dec = DEC_OK;
        if ({1'b0, r_sum} > T_HI) begin
            o_dec = DEC_DN;
        end else if ({1'b0, r_sum} < T_LO) begin
            o_dec = DEC_UP;
        end
    end

endmodule

// File: rtl/ti_adc_os_cal.sv
// Foreground offset-calibration sequencer: shorts the input and walks every way.
// Each way's trim is stepped until its averaged output sits at mid-code. Way w sits at bits [w*width +: width].
module ti_adc_os_cal
    import ti_adc_cal_pkg::*;
#(
    parameter int ADC_WAYS   = 8,
    parameter int ADC_BITS   = 9,
    parameter int OSDAC_BITS = 8,
    parameter int AVG_LOG2   = 4,
    parameter int SETTLE_CYC = 4,
    parameter int DEADBAND   = 1,
    parameter int MAX_ITER   = 64
) (
    input  logic                             adc_coreclk,
    input  logic                             rst,
    input  logic                             cal_start,
    input  logic                             cal_abort,
    input  logic [ADC_WAYS*ADC_BITS-1:0]     adc_data,
    output logic [ADC_WAYS*OSDAC_BITS-1:0]   data_vosp,
    output logic [ADC_WAYS*OSDAC_BITS-1:0]   data_vosn,
    output logic                             cal_short,
    output logic                             cal_busy,
    output logic                             cal_done,
    output logic [0:ADC_WAYS-1]              cal_fail,
    output logic [$clog2(ADC_WAYS)-1:0]      cal_way
);

    localparam int WAY_W      = $clog2(ADC_WAYS);
    localparam int SET_W      = $clog2(SETTLE_CYC + 1);
    localparam int ITER_W     = $clog2(MAX_ITER + 1);
    localparam int OS_MID_I   = os_mid(OSDAC_BITS);
    localparam int TRIM_MAX_I = trim_max(OSDAC_BITS);

    localparam logic        [OSDAC_BITS-1:0] OS_MID    = OSDAC_BITS'(OS_MID_I);
    localparam logic signed [OSDAC_BITS-1:0] TRIM_HI   = OSDAC_BITS'(TRIM_MAX_I);
    localparam logic signed [OSDAC_BITS-1:0] TRIM_LO   = OSDAC_BITS'(-TRIM_MAX_I);
    localparam logic        [WAY_W-1:0]      WAY_LAST  = WAY_W'(ADC_WAYS - 1);
    localparam logic        [SET_W-1:0]      SET_LAST  = SET_W'(SETTLE_CYC - 1);
    localparam logic        [ITER_W-1:0]     ITER_LAST = ITER_W'(MAX_ITER - 1);

    cal_state_t                     r_state;
    logic [SET_W-1:0]               r_set_cnt;
    logic [ITER_W-1:0]              r_iter;
    logic [WAY_W-1:0]               r_way;
    logic                           r_busy;
    logic                           r_done;
    logic [0:ADC_WAYS-1]            r_fail;
    logic signed [OSDAC_BITS-1:0]   r_trim [ADC_WAYS];
    logic [ADC_WAYS*OSDAC_BITS-1:0] r_vosp;
    logic [ADC_WAYS*OSDAC_BITS-1:0] r_vosn;

    logic [ADC_BITS-1:0]            w_sample;
    logic                           w_tc;
    cal_dec_t                       w_dec;
    logic                           w_abort;
    logic                           w_at_limit;
    logic signed [OSDAC_BITS-1:0]   w_trim;
    logic signed [OSDAC_BITS-1:0]   w_trim_step;

    assign w_sample = adc_data[r_way*ADC_BITS +: ADC_BITS];
    assign w_abort  = cal_abort && (r_state inside {SETTLE, ACCUM, DECIDE, NEXT});

    ti_adc_os_accum #(
        .ADC_BITS (ADC_BITS),
        .AVG_LOG2 (AVG_LOG2),
        .DEADBAND (DEADBAND)
    ) u_accum (
        .adc_coreclk (adc_coreclk),
        .rst         (rst),
        .i_clr       (r_state == SETTLE),
        .i_en        (r_state == ACCUM),
        .i_data      (w_sample),
        .o_tc        (w_tc),
        .o_dec       (w_dec)
    );

    always_comb begin
        w_trim      = r_trim[r_way];
        w_trim_step = (w_dec == DEC_UP) ? w_trim + OSDAC_BITS'(1) : w_trim - OSDAC_BITS'(1);
        w_at_limit  = (w_dec == DEC_UP && w_trim == TRIM_HI) ||
                      (w_dec == DEC_DN && w_trim == TRIM_LO);
    end

    always_ff @(posedge adc_coreclk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_set_cnt <= '0;
            r_iter    <= '0;
            r_way     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_fail    <= '0;
            r_vosp    <= {ADC_WAYS{OS_MID}};
            r_vosn    <= {ADC_WAYS{OS_MID}};
            // NOTE: the trim array is reset on purpose; the offset DACs must never see an unknown code.
            for (int w = 0; w < ADC_WAYS; w++) begin
                r_trim[w] <= '0;
            end
        end else if (w_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (cal_start && !cal_abort) begin
                    r_state   <= SETTLE;
                    r_busy    <= 1'b1;
                    r_done    <= 1'b0;
                    r_fail    <= '0;
                    r_way     <= '0;
                    r_iter    <= '0;
                    r_set_cnt <= '0;
                end
                SETTLE: if (r_set_cnt == SET_LAST) begin
                    r_set_cnt <= '0;
                    r_state   <= ACCUM;
                end else begin
                    r_set_cnt <= r_set_cnt + SET_W'(1);
                end
                ACCUM: if (w_tc) r_state <= DECIDE;
                DECIDE: begin
                    if (w_dec == DEC_OK) begin
                        r_state <= NEXT;
                    end else if (w_at_limit) begin
                        r_fail[r_way] <= 1'b1;
                        r_state       <= NEXT;
                    end else begin
                        r_trim[r_way]                          <= w_trim_step;
                        r_vosp[r_way*OSDAC_BITS +: OSDAC_BITS] <= OS_MID + w_trim_step;
                        r_vosn[r_way*OSDAC_BITS +: OSDAC_BITS] <= OS_MID - w_trim_step;
                        // The last allowed step is still applied before the way is failed.
                        if (r_iter == ITER_LAST) begin
                            r_fail[r_way] <= 1'b1;
                            r_state       <= NEXT;
                        end else begin
                            r_iter  <= r_iter + ITER_W'(1);
                            r_state <= SETTLE;
                        end
                    end
                end
                NEXT: if (r_way == WAY_LAST) begin
                    r_state <= DONE;
                end else begin
                    r_way   <= r_way + WAY_W'(1);
                    r_iter  <= '0;
                    r_state <= SETTLE;
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_vosp = r_vosp;
    assign data_vosn = r_vosn;
    assign cal_busy  = r_busy;
    assign cal_short = r_busy;
    assign cal_done  = r_done;
    assign cal_fail  = r_fail;
    assign cal_way   = r_way;

endmodule

// File: tb/tb_ti_adc_os_cal.sv
// Self-checking bench for ti_adc_os_cal with a per-way offset plant model.
// Each way outputs 256 + offs[w], plus its own trim when track[w] is set.
module tb_ti_adc_os_cal;

    localparam int WAYS = 8;
    localparam int AB   = 9;
    localparam int OB   = 8;

    typedef struct {
        string name;
        int    way;
        int    offs;
        bit    track;
        int    exp_trim;
        bit    exp_fail;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cal_start = 1'b0;
    logic              cal_abort = 1'b0;
    logic [WAYS*AB-1:0] adc_data;
    logic [WAYS*OB-1:0] data_vosp;
    logic [WAYS*OB-1:0] data_vosn;
    logic              cal_short;
    logic              cal_busy;
    logic              cal_done;
    logic [0:WAYS-1]   cal_fail;
    logic [2:0]        cal_way;

    int   offs  [WAYS];
    bit   track [WAYS];
    vec_t vecs  [8];
    int   n_pass  = 0;
    int   n_total = 0;

    ti_adc_os_cal dut (
        .adc_coreclk (clk),
        .rst         (rst),
        .cal_start   (cal_start),
        .cal_abort   (cal_abort),
        .adc_data    (adc_data),
        .data_vosp   (data_vosp),
        .data_vosn   (data_vosn),
        .cal_short   (cal_short),
        .cal_busy    (cal_busy),
        .cal_done    (cal_done),
        .cal_fail    (cal_fail),
        .cal_way     (cal_way)
    );

    always #5 clk = ~clk;

    always_comb begin
        adc_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            adc_data[w*AB +: AB] = AB'(256 + offs[w] +
                                   (track[w] ? int'(data_vosp[w*OB +: OB]) - 128 : 0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int vosp_of(input int w);
        return int'(data_vosp[w*OB +: OB]);
    endfunction

    function automatic int vosn_of(input int w);
        return int'(data_vosn[w*OB +: OB]);
    endfunction

    task automatic check_way(input string name, input int w, input int trim);
        check($sformatf("%s_vosp%0d", name, w), vosp_of(w), 128 + trim);
        check($sformatf("%s_vosn%0d", name, w), vosn_of(w), 128 - trim);
    endtask

    task automatic do_reset();
        cal_start = 1'b0;
        cal_abort = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            offs[w]  = 0;
            track[w] = 1'b0;
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic pulse_start();
        cal_start = 1'b1;
        step();
        cal_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!cal_done && n < budget) begin
            step();
            n++;
        end
        check({name, "_done"}, int'(cal_done), 1);
    endtask

    initial begin
        logic [0:WAYS-1] ef;
        int n;

        vecs[0] = '{"all_mid",     0,   0, 1'b0,   0, 1'b0};
        vecs[1] = '{"way3_hi",     3,  10, 1'b1,  -9, 1'b0};
        vecs[2] = '{"way5_iter",   5, 200, 1'b1, -64, 1'b1};
        vecs[3] = '{"way0_lo",     0, -10, 1'b1,   9, 1'b0};
        vecs[4] = '{"way7_db_hi",  7,   1, 1'b0,   0, 1'b0};
        vecs[5] = '{"way6_db_lo",  6,  -1, 1'b0,   0, 1'b0};
        vecs[6] = '{"way2_out_db", 2,   2, 1'b0, -64, 1'b1};
        vecs[7] = '{"way4_edge",   4,  -2, 1'b1,   1, 1'b0};

        // Reset state, no start.
        do_reset();
        step();
        check("rst_busy",  int'(cal_busy),  0);
        check("rst_short", int'(cal_short), 0);
        check("rst_done",  int'(cal_done),  0);
        check("rst_fail",  int'(cal_fail),  0);
        check("rst_way",   int'(cal_way),   0);
        for (int w = 0; w < WAYS; w++) check_way("rst", w, 0);

        // Exact run latency, with a start pulse mid-run that must be ignored.
        do_reset();
        pulse_start();
        check("lat_busy",  int'(cal_busy),  1);
        check("lat_short", int'(cal_short), 1);
        check("lat_way0",  int'(cal_way),   0);
        repeat (48) step();
        pulse_start();
        check("lat_way2_after_restart_req", int'(cal_way), 2);
        repeat (127) step();
        check("lat_done_early", int'(cal_done), 0);
        check("lat_busy_176",   int'(cal_busy), 1);
        step();
        check("lat_done_177",   int'(cal_done),  1);
        check("lat_busy_off",   int'(cal_busy),  0);
        check("lat_short_off",  int'(cal_short), 0);
        check("lat_way_last",   int'(cal_way),   7);
        check("lat_fail",       int'(cal_fail),  0);
        for (int w = 0; w < WAYS; w++) check_way("lat", w, 0);

        // Abort and start together in IDLE: start ignored, done held.
        cal_start = 1'b1;
        cal_abort = 1'b1;
        step();
        cal_start = 1'b0;
        cal_abort = 1'b0;
        step();
        check("idle_abort_busy", int'(cal_busy), 0);
        check("idle_abort_done", int'(cal_done), 1);

        // New code visible the cycle after DECIDE; async reset mid-ACCUM.
        do_reset();
        offs[0]  = 10;
        track[0] = 1'b1;
        pulse_start();
        repeat (20) step();
        check("decide_pre_vosp0", vosp_of(0), 128);
        step();
        check_way("decide_post", 0, -1);
        repeat (9) step();
        #2 rst = 1'b1;
        #1;
        check_way("arst", 0, 0);
        check("arst_busy",  int'(cal_busy),  0);
        check("arst_short", int'(cal_short), 0);
        check("arst_done",  int'(cal_done),  0);
        check("arst_way",   int'(cal_way),   0);
        #2 rst = 1'b0;
        step();

        // Abort during way-2 ACCUM, then restart from way 0 with trims held.
        do_reset();
        offs[0]  = 10;
        track[0] = 1'b1;
        offs[1]  = -10;
        track[1] = 1'b1;
        offs[2]  = 5;
        pulse_start();
        n = 0;
        while (cal_way != 3'd2 && n < 2000) begin
            step();
            n++;
        end
        check("abort_reach_way2", int'(cal_way), 2);
        repeat (6) step();
        cal_abort = 1'b1;
        step();
        cal_abort = 1'b0;
        check("abort_busy",  int'(cal_busy),  0);
        check("abort_short", int'(cal_short), 0);
        check("abort_done",  int'(cal_done),  0);
        check("abort_fail",  int'(cal_fail),  0);
        check_way("abort", 0, -9);
        check_way("abort", 1, 9);
        check_way("abort", 2, 0);
        repeat (3) step();
        check("abort_stays_idle", int'(cal_busy), 0);
        pulse_start();
        check("restart_busy", int'(cal_busy), 1);
        check("restart_way",  int'(cal_way),  0);
        repeat (21) step();
        check("restart_way0_hold", int'(cal_way), 0);
        step();
        check("restart_way1", int'(cal_way), 1);
        check_way("restart", 0, -9);
        cal_abort = 1'b1;
        step();
        cal_abort = 1'b0;

        // Table-driven full calibrations.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            offs[vecs[i].way]  = vecs[i].offs;
            track[vecs[i].way] = vecs[i].track;
            pulse_start();
            wait_done(3000, vecs[i].name);
            check({vecs[i].name, "_busy"}, int'(cal_busy), 0);
            ef = '0;
            if (vecs[i].exp_fail) ef[vecs[i].way] = 1'b1;
            check({vecs[i].name, "_fail"}, int'(cal_fail), int'(ef));
            for (int w = 0; w < WAYS; w++) begin
                check_way(vecs[i].name, w, (w == vecs[i].way) ? vecs[i].exp_trim : 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
